// File: rtl/rf_pkg.sv
// Shared definitions for the integer register-file writeback path.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic circular buffer with occupancy count. Entries are also exported
// in age order (index 0 = oldest) so a caller can scan them for matches.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [W-1:0]              din_i,
  input  logic                      pop_i,
  output logic [W-1:0]              head_o,
  output logic [CW-1:0]             count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DEPTH-1:0][W-1:0]   age_data_o,
  output logic [DEPTH-1:0]          age_vld_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= din_i;
  end

  always_comb begin
    age_data_o = '0;
    age_vld_o  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_data_o[k] = mem_q[head_q + PW'(k)];
      age_vld_o[k]  = (CW'(k) < count_q);
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Writeback queue: arbitrates ALU/load results into an in-order FIFO, drains
// it into the register-file write port and offers a bypass view of queued data.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            rf_gnt,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wr,
  output logic [XLEN-1:0] rf_din,
  input  logic [AW-1:0]   a0,
  input  logic [AW-1:0]   a1,
  output logic            hit0,
  output logic            hit1,
  output logic [XLEN-1:0] byp0,
  output logic [XLEN-1:0] byp1,
  output logic [CW-1:0]   count
);

  localparam int EW = AW + XLEN;

  // Handshake: a producer transfers on a rising edge where valid && ready.
  // Load wins over ALU; ready is derived from full only, never from a same-cycle pop.
  logic            full, empty, push, ld_fire;
  logic [AW-1:0]   push_rd;
  logic [XLEN-1:0] push_data;
  logic [EW-1:0]   head;
  logic [DEPTH-1:0][EW-1:0] age_data;
  logic [DEPTH-1:0]         age_vld;

  assign ld_ready  = !full && !rst;
  assign alu_ready = !full && !ld_valid && !rst;
  assign ld_fire   = ld_valid && ld_ready;

  assign push_rd   = ld_fire ? ld_rd : alu_rd;
  assign push_data = ld_fire ? ld_data : alu_data;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push      = (ld_fire || (alu_valid && alu_ready)) && (push_rd != AW'(REG_ZERO));

  assign rf_we  = !empty && rf_gnt;
  assign rf_wr  = empty ? '0 : head[EW-1:XLEN];
  assign rf_din = empty ? '0 : head[XLEN-1:0];

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .din_i      ({push_rd, push_data}),
    .pop_i      (rf_we),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .age_data_o (age_data),
    .age_vld_o  (age_vld)
  );

  // Scan oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    byp0 = '0;
    byp1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_vld[k] && (a0 != '0) && (age_data[k][EW-1:XLEN] == a0)) begin
        hit0 = 1'b1;
        byp0 = age_data[k][XLEN-1:0];
      end
      if (age_vld[k] && (a1 != '0) && (age_data[k][EW-1:XLEN] == a1)) begin
        hit1 = 1'b1;
        byp1 = age_data[k][XLEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, single write, arbitration, full,
// bypass, x0 filter and asynchronous reset with entries queued.
module tb_rf_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, ld_valid, rf_gnt;
  logic [AW-1:0]   alu_rd, ld_rd, a0, a1;
  logic [XLEN-1:0] alu_data, ld_data;
  logic            alu_ready, ld_ready, rf_we, hit0, hit1;
  logic [AW-1:0]   rf_wr;
  logic [XLEN-1:0] rf_din, byp0, byp1;
  logic [CW-1:0]   count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_gnt(rf_gnt), .rf_we(rf_we), .rf_wr(rf_wr), .rf_din(rf_din),
    .a0(a0), .a1(a1), .hit0(hit0), .hit1(hit1), .byp0(byp0), .byp1(byp1),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic alu_push(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    cyc();
    alu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; ld_valid = 0; rf_gnt = 0;
    alu_rd = 0; ld_rd = 0; alu_data = 0; ld_data = 0; a0 = 0; a1 = 0;
    cyc(); cyc();
    chk("rst_count", count, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_wr", rf_wr, 0);
    chk("rst_din", rf_din, 0);
    rst = 1'b0;
    settle();
    chk("post_rst_ld_ready", ld_ready, 1);
    chk("post_rst_alu_ready", alu_ready, 1);

    // Single write with grant held high.
    rf_gnt = 1'b1;
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    settle();
    chk("single_alu_ready", alu_ready, 1);
    cyc();
    alu_valid = 1'b0;
    settle();
    chk("single_we", rf_we, 1);
    chk("single_wr", rf_wr, 5);
    chk("single_din", rf_din, 32'hDEADBEEF);
    chk("single_count", count, 1);
    cyc();
    chk("single_drained", count, 0);
    chk("single_we_off", rf_we, 0);

    // Arbitration: load beats ALU in the same cycle.
    alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_0333;
    ld_valid = 1;  ld_rd = 4;  ld_data = 32'h0000_0444;
    settle();
    chk("arb_ld_ready", ld_ready, 1);
    chk("arb_alu_ready", alu_ready, 0);
    cyc();
    ld_valid = 0;
    settle();
    chk("arb_alu_ready2", alu_ready, 1);
    chk("arb_first_wr", rf_wr, 4);
    chk("arb_first_din", rf_din, 32'h0000_0444);
    chk("arb_first_we", rf_we, 1);
    cyc();
    alu_valid = 0;
    settle();
    chk("arb_second_wr", rf_wr, 3);
    chk("arb_second_din", rf_din, 32'h0000_0333);
    chk("arb_second_count", count, 1);
    cyc();
    chk("arb_drained", count, 0);

    // Full: no grant, four pushes; pointers are mid-buffer so this wraps.
    rf_gnt = 0;
    for (int i = 1; i <= 4; i++) alu_push(AW'(10 + i), XLEN'(32'hA0 + i));
    chk("full_count", count, 4);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_ld_ready", ld_ready, 0);
    chk("full_we_nognt", rf_we, 0);
    rf_gnt = 1;
    settle();
    chk("full_ready_during_pop", ld_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("full_drain_we", rf_we, 1);
      chk("full_drain_wr", rf_wr, 64'(10 + i));
      chk("full_drain_din", rf_din, 64'(32'hA0 + i));
      cyc();
    end
    chk("full_empty", count, 0);
    chk("full_ready_after", alu_ready, 1);

    // Bypass: youngest match wins, a==0 never hits.
    rf_gnt = 0;
    alu_push(7, 32'h11);
    alu_push(7, 32'h22);
    a0 = 7; a1 = 0;
    settle();
    chk("byp_hit0", hit0, 1);
    chk("byp_byp0", byp0, 32'h22);
    chk("byp_hit1", hit1, 0);
    chk("byp_byp1", byp1, 0);
    a1 = 9;
    settle();
    chk("byp_miss_hit1", hit1, 0);
    rf_gnt = 1;
    settle();
    chk("byp_head_written_hit", hit0, 1);
    chk("byp_head_written_val", byp0, 32'h22);
    cyc();
    chk("byp_one_left", byp0, 32'h22);
    cyc();
    chk("byp_gone_hit", hit0, 0);
    chk("byp_gone_val", byp0, 0);

    // x0 filter.
    a0 = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    settle();
    chk("x0_ready", alu_ready, 1);
    cyc();
    alu_valid = 0;
    settle();
    chk("x0_count", count, 0);
    chk("x0_we", rf_we, 0);
    cyc();
    chk("x0_we_later", rf_we, 0);

    // Asynchronous reset with three entries queued.
    rf_gnt = 0; a0 = 21;
    for (int i = 0; i < 3; i++) alu_push(AW'(20 + i), XLEN'(i + 1));
    chk("rst_mid_count_before", count, 3);
    chk("rst_mid_hit_before", hit0, 1);
    chk("rst_mid_byp_before", byp0, 2);
    #2 rst = 1; rf_gnt = 1;
    settle();
    chk("rst_mid_count", count, 0);
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_hit0", hit0, 0);
    chk("rst_mid_byp0", byp0, 0);
    chk("rst_mid_ld_ready", ld_ready, 0);
    cyc();
    chk("rst_mid_we_held", rf_we, 0);
    rst = 0;
    settle();
    chk("rst_release_ld_ready", ld_ready, 1);
    chk("rst_release_count", count, 0);
    cyc();
    chk("rst_release_we", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback queue that drives the write port of the 32×32 integer register file. It accepts results from the ALU and the load unit through valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per granted cycle into the register file's `wr`/`we`/`din` port. It also exposes a bypass lookup so that the decode-stage read addresses (`a0`/`a1`) can see results that are queued but not yet written.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `alu_valid`  in  1  ALU result valid.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `ld_valid`  in  1  load result valid.
- `ld_rd`  in  AW  load destination register.
- `ld_data`  in  XLEN  load result.
- `ld_ready`  out  1  load result accepted this cycle.
- `rf_gnt`  in  1  write port available to this block this cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_wr`  out  AW  register-file write address.
- `rf_din`  out  XLEN  register-file write data.
- `a0`, `a1`  in  AW  lookup addresses; these are the same as the register file read addresses.
- `hit0`, `hit1`  out  1  a queued entry targets `a0` / `a1`.
- `byp0`, `byp1`  out  XLEN  data of the youngest matching entry; zero when there is no hit.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- **Storage:** circular FIFO with head/tail pointers plus an occupancy count. Each entry holds `{rd, data}`.
- **Enqueue:** at most one per cycle.
  - Load has priority over ALU.
  - `ld_ready = !full && !rst`.
  - `alu_ready = !full && !ld_valid && !rst`.
  - A transfer occurs when valid && ready on a clock edge.
- **x0 filter:** a transfer with `rd == 0` completes the handshake but is not enqueued; `count` is unchanged.
- **Drain:**
  - `rf_we = !empty && rf_gnt`.
  - `rf_wr` and `rf_din` always show the head entry; they are zero when the FIFO is empty.
  - The head pops on the edge where `rf_we` is 1.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Full:** `ready` is computed from `full` only; a same-cycle pop does not open a slot.
- **Bypass:**
  - Compare `a0`/`a1` against every occupied entry, including the head entry being written this cycle.
  - Return the youngest match by age order from the tail.
  - `a == 0` never hits.
  - Purely combinational; incoming same-cycle producer data is not bypassed.
- **Pointer wrap:** head and tail wrap modulo `DEPTH`.
- **Reset (asynchronous):**
  - `count = 0`, pointers = 0, entry contents are don't-care.
  - `rf_we = 0`, `hit* = 0`, `byp* = 0`, `rf_wr = 0`, `rf_din = 0`.
  - Both `ready` outputs are 0 while `rst` is high.
- **Reset mid-operation:** queued entries are discarded; no partial write is issued.

## Timing
- Enqueue-to-`rf_we` latency: 1 cycle minimum. An entry pushed at edge N can be written in the cycle after edge N if `rf_gnt` is high.
- Bypass has zero latency: it reflects the state after the last edge.
- Sustained throughput: 1 entry/cycle while `rf_gnt` stays high.
- `ready` outputs combinationally depend on `ld_valid` and `rst`; they have no path from `alu_valid`.

## Structure
- Shared package `rf_pkg`:
  - `XLEN`, `AW` constants.
  - `wb_entry_t` struct `{rd, data}`.
  - `REG_ZERO` constant.
- Sub-module `wb_fifo`: generic circular buffer with push/pop/count and per-entry valid/age visibility for the bypass compare.
- Top level: arbitration, x0 filter, bypass priority logic.

## Test plan
1. **Reset:** assert `rst` mid-cycle with 3 entries queued → `count=0`, `rf_we=0`, `hit0=0` immediately; after release, `ld_ready=1`.
2. **Single write:** `alu_valid=1`, `rd=5`, `data=0xDEADBEEF`, `rf_gnt=1` → next cycle `rf_we=1`, `rf_wr=5`, `rf_din=0xDEADBEEF`; `count` returns to 0.
3. **Arbitration:** ALU `rd=3` and load `rd=4` valid in the same cycle → `ld_ready=1`, `alu_ready=0`; load written first, ALU entry written the following cycle.
4. **Full:** `rf_gnt=0`, push 4 entries → `count=4`, both `ready=0`; raise `rf_gnt` → 4 consecutive writes in FIFO order, then `ready=1`.
5. **Bypass:** queue `rd=7/0x11` then `rd=7/0x22` with `rf_gnt=0`, `a0=7`, `a1=0` → `hit0=1`, `byp0=0x22`, `hit1=0`, `byp1=0`.
6. **x0 filter:** push with `rd=0`, `data=0xFFFFFFFF` → handshake completes, `count` stays 0, `rf_we` never asserts.
